mul_issue_queue: RTL and testbench
==================================

// Module: mul_issue_queue
// PURPOSE
//  Issue stage directly upstream of the 32-bit iterative multiplier (MUL/MULH/MULHSU/MULHU).
//  Buffers tagged M-extension multiply ops from dispatch in a DEPTH-entry FIFO.
//  Issues one op at a time to the multiplier, captures its result, and presents {tag, data}
//  on a valid/ready completion port toward the CDB arbiter.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of 2, >=2)
//  TAG_W  5  ROB tag width
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       asynchronous, active-low reset
//  in_valid    in   1       dispatch op valid
//  in_ready    out  1       FIFO can accept (count < DEPTH)
//  in_op       in   5       10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU
//  in_rs1      in   32      operand A
//  in_rs2      in   32      operand B
//  in_tag      in   TAG_W   ROB tag
//  mul_start   out  1       one-cycle start pulse to multiplier
//  mul_op_sel  out  5       op to multiplier, valid while mul_start=1
//  mul_rs1     out  32      operand A to multiplier, valid while mul_start=1
//  mul_rs2     out  32      operand B to multiplier, valid while mul_start=1
//  mul_busy    in   1       multiplier busy
//  mul_done    in   1       multiplier done pulse; mul_result valid the NEXT cycle
//  mul_result  in   32      multiplier result
//  out_valid   out  1       completion valid
//  out_ready   in   1       CDB accepts completion
//  out_tag     out  TAG_W   completion tag
//  out_data    out  32      completion data
//  q_count     out  $clog2(DEPTH)+1  current FIFO occupancy
//  flush       in   1       pipeline flush (only with MUL_FLUSH_EN)
// BEHAVIOUR
//  Reset: FIFO empty, q_count=0, state IDLE, mul_start=0, out_valid=0, out_tag=0, out_data=0.
//   in_ready=1 after reset. Multiplier shares rst_n.
//  Push: on in_valid&in_ready, write {op,rs1,rs2,tag} at tail.
//   in_ready depends only on count; a pop in the same cycle does not free a slot early.
//  FSM:
//   IDLE  -> ISSUE when FIFO non-empty & !mul_busy & !out_valid.
//   ISSUE -> WAIT; one cycle, mul_start=1, mul_* driven from head entry.
//            Head popped and tag latched at the end of the cycle.
//   WAIT  -> CAPT on mul_done.
//   CAPT  -> IDLE; out_data<=mul_result, out_tag<=latched tag, out_valid<=1.
//  Illegal op (in_op outside 10000..10011): no mul_start. ISSUE goes straight to CAPT with
//   out_data=0, tag preserved.
//  out_valid holds, with out_tag/out_data stable, until out_valid&out_ready; then it clears.
//   New issue waits until the completion slot is empty.
//  Latency, legal op into an empty idle block: accepted in cycle 0, mul_start in cycle 1,
//   mul_done in cycle 35, out_valid in cycle 37 (with out_ready=1 it is held 1 cycle).
//   Throughput: one op per 37 cycles.
//  Ordering: completions leave in strict FIFO order.
//  Simultaneous push + pop: both take effect; q_count is unchanged.
//  Pointers wrap modulo DEPTH.
// CONFIGURATION
//  MUL_FLUSH_EN defined: flush port exists. On flush=1 (highest priority):
//   - FIFO emptied, any same-cycle push ignored, out_valid cleared.
//   - From ISSUE or WAIT, go to DRAIN; DRAIN -> IDLE the cycle after mul_done.
//     mul_result is discarded and nothing issues until then.
//  MUL_FLUSH_EN undefined: no flush port, no DRAIN state; ops always complete.
// TESTING
//  Single MULHU rs1=FFFFFFFF rs2=FFFFFFFF tag=3 ->
//   out_data=FFFFFFFE, out_tag=3, out_valid in cycle 37.
//  MUL 7 x -3 (FFFFFFFD), tag 1 -> out_data=FFFFFFEB.
//  MULH 80000000 x 80000000 -> out_data=40000000.
//  MULHSU FFFFFFFF x 2 -> out_data=FFFFFFFF.
//  Push DEPTH+1 ops back-to-back -> in_ready=0 once q_count=DEPTH.
//   Tags complete in push order; out_ready=0 stalls hold out_tag/out_data stable.
//  Illegal op 00101, tag 9 -> mul_start never asserted; out_data=0, out_tag=9.
//  With MUL_FLUSH_EN: flush in cycle 10 of an in-flight op with 2 queued ->
//   q_count=0, no out_valid; a new op pushed after DRAIN completes normally.

Source files
------------

// File: rtl/mul_issue_queue_if.sv
// Dispatch, multiplier and completion signals of the multiply issue queue.
// MUL_FLUSH_EN adds the flush input.
interface mul_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [4:0]               in_op;
  logic [31:0]              in_rs1;
  logic [31:0]              in_rs2;
  logic [TAG_W-1:0]         in_tag;
  logic                     mul_start;
  logic [4:0]               mul_op_sel;
  logic [31:0]              mul_rs1;
  logic [31:0]              mul_rs2;
  logic                     mul_busy;
  logic                     mul_done;
  logic [31:0]              mul_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [TAG_W-1:0]         out_tag;
  logic [31:0]              out_data;
  logic [$clog2(DEPTH):0]   q_count;
`ifdef MUL_FLUSH_EN
  logic                     flush;

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, mul_busy, mul_done, mul_result,
           out_ready, flush,
    output in_ready, mul_start, mul_op_sel, mul_rs1, mul_rs2, out_valid, out_tag,
           out_data, q_count
  );
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, mul_busy, mul_done, mul_result,
           out_ready, flush,
    input  in_ready, mul_start, mul_op_sel, mul_rs1, mul_rs2, out_valid, out_tag,
           out_data, q_count
  );
`else
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, mul_busy, mul_done, mul_result,
           out_ready,
    output in_ready, mul_start, mul_op_sel, mul_rs1, mul_rs2, out_valid, out_tag,
           out_data, q_count
  );
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, mul_busy, mul_done, mul_result,
           out_ready,
    input  in_ready, mul_start, mul_op_sel, mul_rs1, mul_rs2, out_valid, out_tag,
           out_data, q_count
  );
`endif
endinterface

// File: rtl/mul_issue_queue.sv
// Multiply issue queue: DEPTH-entry op FIFO feeding an iterative multiplier, one op in flight.
// Latency: push in cycle 0 -> mul_start cycle 1 -> out_valid cycle 37; in_ready = (count < DEPTH),
// completion held until out_ready. MUL_FLUSH_EN adds flush with a DRAIN state.
module mul_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_issue_queue_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
  } entry_t;

`ifdef MUL_FLUSH_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPT} state_t;
`endif

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           new_entry;
  state_t           state;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [TAG_W-1:0] tag_q, out_tag_q;
  logic [31:0]      out_data_q;
  logic             illegal_q, out_valid_q, mul_start_q;
  logic             flush, push, pop, issue_go;
  logic [4:0]       next_op;

  function automatic logic is_legal(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

`ifdef MUL_FLUSH_EN
  assign flush = io.flush;
`else
  assign flush = 1'b0;
`endif

  assign head      = mem[rd_ptr];
  assign new_entry = '{op: io.in_op, rs1: io.in_rs1, rs2: io.in_rs2, tag: io.in_tag};
  assign push      = io.in_valid & io.in_ready & ~flush;
  assign pop       = (state == ISSUE);
  // An op pushed into an empty queue is issued straight away, so its opcode comes from the input.
  assign next_op   = (count == '0) ? io.in_op : head.op;
  assign issue_go  = (state == IDLE) & ((count != '0) | push) & ~io.mul_busy &
                     (~out_valid_q | io.out_ready) & ~flush;

  assign io.in_ready   = (count != FULL);
  assign io.q_count    = count;
  assign io.mul_start  = mul_start_q;
  assign io.mul_op_sel = head.op;
  assign io.mul_rs1    = head.rs1;
  assign io.mul_rs2    = head.rs2;
  assign io.out_valid  = out_valid_q;
  assign io.out_tag    = out_tag_q;
  assign io.out_data   = out_data_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tag_q       <= '0;
      illegal_q   <= 1'b0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (out_valid_q && io.out_ready) out_valid_q <= 1'b0;
      mul_start_q <= 1'b0;

      case (state)
        IDLE: if (issue_go) begin
          state       <= ISSUE;
          mul_start_q <= is_legal(next_op);
        end
        ISSUE: begin
          tag_q     <= head.tag;
          illegal_q <= ~is_legal(head.op);
          state     <= is_legal(head.op) ? WAIT : CAPT;
        end
        WAIT: if (io.mul_done) state <= CAPT;
        CAPT: begin
          out_valid_q <= 1'b1;
          out_tag_q   <= tag_q;
          out_data_q  <= illegal_q ? 32'd0 : io.mul_result;
          state       <= IDLE;
        end
`ifdef MUL_FLUSH_EN
        DRAIN: if (io.mul_done) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase

`ifdef MUL_FLUSH_EN
      // A started multiply cannot be cancelled; DRAIN waits for it without keeping the result.
      if (flush) begin
        rd_ptr      <= wr_ptr;
        count       <= '0;
        out_valid_q <= 1'b0;
        case (state)
          ISSUE:   state <= is_legal(head.op) ? DRAIN : IDLE;
          WAIT:    state <= io.mul_done ? IDLE : DRAIN;
          CAPT:    state <= IDLE;
          default: ;
        endcase
      end
`endif
    end
  end
endmodule

// File: tb/tb_mul_issue_queue.sv
// Bench for mul_issue_queue with a 34-cycle iterative multiplier model and a completion scoreboard.
module tb_mul_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mul_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) io();
  mul_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  int checks = 0, errors = 0, cyc = 0;
  int starts = 0, compl = 0, vcyc = 0, last_start_cyc = 0, rise_cyc = 0;
  logic [TAG_W-1:0] last_tag, held_tag;
  logic [31:0] last_data, held_data;
  logic hold_pend = 1'b0, prev_valid = 1'b0, flushing;

  typedef struct { logic [TAG_W-1:0] tag; logic [31:0] data; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [TAG_W-1:0] tag;
    logic [31:0] exp_data; bit legal;
  } vec_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit op_legal(input logic [4:0] op);
    return (op >= 5'b10000) && (op <= 5'b10011);
  endfunction

  function automatic logic [31:0] ref_mul(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 5'b10001 || op == 5'b10010) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 5'b10001) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 5'b10000) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: done 34 cycles after start, result valid only in the cycle after done.
  logic       m_busy;
  logic [5:0] m_cnt;
  logic [4:0] m_op;
  logic [31:0] m_a, m_b;
  assign io.mul_busy = m_busy;
  assign io.mul_done = m_busy && (m_cnt == 6'd0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 6'd0; m_op <= 5'd0; m_a <= 32'd0; m_b <= 32'd0;
      io.mul_result <= 32'd0;
    end else begin
      io.mul_result <= 32'hDEADBEEF;
      if (io.mul_start) begin
        m_busy <= 1'b1; m_cnt <= 6'd33;
        m_op <= io.mul_op_sel; m_a <= io.mul_rs1; m_b <= io.mul_rs2;
      end else if (m_busy) begin
        if (m_cnt == 6'd0) begin
          m_busy <= 1'b0;
          io.mul_result <= ref_mul(m_op, m_a, m_b);
        end else m_cnt <= m_cnt - 6'd1;
      end
    end
  end

`ifdef MUL_FLUSH_EN
  assign flushing = io.flush;
`else
  assign flushing = 1'b0;
`endif

  always @(negedge clk) begin
    if (rst_n) begin
      if (io.mul_start) begin
        starts++;
        last_start_cyc = cyc;
        check("start_while_busy", {63'd0, io.mul_busy}, 64'd0);
      end
      if (hold_pend) begin
        check("hold_valid", {63'd0, io.out_valid}, 64'd1);
        check("hold_tag", {59'd0, io.out_tag}, {59'd0, held_tag});
        check("hold_data", {32'd0, io.out_data}, {32'd0, held_data});
      end
      if (io.out_valid) begin
        vcyc++;
        if (!prev_valid) rise_cyc = cyc;
      end
      if (io.out_valid && io.out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: completion tag %0h data %0h with nothing expected",
                   io.out_tag, io.out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_tag", {59'd0, io.out_tag}, {59'd0, e.tag});
          check("out_data", {32'd0, io.out_data}, {32'd0, e.data});
          last_tag = io.out_tag; last_data = io.out_data; compl++;
        end
      end
      hold_pend = io.out_valid && !io.out_ready;
      held_tag = io.out_tag; held_data = io.out_data; prev_valid = io.out_valid;
      if (flushing) begin
        sb.delete();
        hold_pend = 1'b0;
      end else if (io.in_valid && io.in_ready) begin
        sb.push_back('{tag: io.in_tag,
                       data: op_legal(io.in_op) ? ref_mul(io.in_op, io.in_rs1, io.in_rs2) : 32'd0});
      end
    end
  end

  task automatic push_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
    io.in_valid = 1'b1; io.in_op = op; io.in_rs1 = a; io.in_rs2 = b; io.in_tag = tag;
    for (int n = 0; n < 400 && !io.in_ready; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || io.out_valid) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: %0d completions outstanding after %0d cycles", name, sb.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int c0, s0, v0, k0;
    vecs[0] = '{5'b10000, 32'd7,          32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 1'b1};
    vecs[1] = '{5'b10001, 32'h80000000,   32'h80000000, 5'd2,  32'h40000000, 1'b1};
    vecs[2] = '{5'b10010, 32'hFFFFFFFF,   32'd2,        5'd4,  32'hFFFFFFFF, 1'b1};
    vecs[3] = '{5'b10011, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 1'b1};
    vecs[4] = '{5'b00101, 32'd11,         32'd12,       5'd9,  32'd0,        1'b0};
    vecs[5] = '{5'b10100, 32'd5,          32'd6,        5'd10, 32'd0,        1'b0};
    vecs[6] = '{5'b10000, 32'h12345678,   32'd16,       5'd31, 32'h23456780, 1'b1};
    vecs[7] = '{5'b10011, 32'h80000000,   32'd2,        5'd0,  32'h00000001, 1'b1};
    vecs[8] = '{5'b10001, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'h00000000, 1'b1};
    vecs[9] = '{5'b10010, 32'h80000000,   32'hFFFFFFFF, 5'd12, 32'h80000000, 1'b1};

    io.in_valid = 1'b0; io.in_op = '0; io.in_rs1 = '0; io.in_rs2 = '0; io.in_tag = '0;
    io.out_ready = 1'b1;
`ifdef MUL_FLUSH_EN
    io.flush = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #10;
    check("rst_q_count", {61'd0, io.q_count}, 64'd0);
    check("rst_out_valid", {63'd0, io.out_valid}, 64'd0);
    check("rst_out_tag", {59'd0, io.out_tag}, 64'd0);
    check("rst_out_data", {32'd0, io.out_data}, 64'd0);
    check("rst_mul_start", {63'd0, io.mul_start}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    check("rst_in_ready", {63'd0, io.in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // Latency of a single MULHU into an empty idle queue
    c0 = cyc; v0 = vcyc;
    push_op(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    wait_idle("latency");
    check("lat_start_cycle", 64'(last_start_cyc - c0), 64'd1);
    check("lat_valid_cycle", 64'(rise_cyc - c0), 64'd37);
    check("lat_valid_len", 64'(vcyc - v0), 64'd1);
    check("lat_tag", {59'd0, last_tag}, 64'd3);
    check("lat_data", {32'd0, last_data}, 64'hFFFFFFFE);

    for (int i = 0; i < 10; i++) begin
      s0 = starts;
      push_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_idle("vec");
      check($sformatf("vec%0d_tag", i), {59'd0, last_tag}, {59'd0, vecs[i].tag});
      check($sformatf("vec%0d_data", i), {32'd0, last_data}, {32'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_starts", i), 64'(starts - s0), {63'd0, vecs[i].legal});
    end

    // DEPTH+1 back-to-back pushes against a stalled completion port
    io.out_ready = 1'b0;
    k0 = compl;
    for (int i = 0; i < DEPTH + 1; i++)
      push_op(5'b10000 + 5'($urandom_range(0, 3)), $urandom, $urandom, 5'(16 + i));
    check("full_q_count", {61'd0, io.q_count}, 64'(DEPTH));
    check("full_in_ready", {63'd0, io.in_ready}, 64'd0);
    repeat (60) @(posedge clk);
    #1;
    check("stall_valid", {63'd0, io.out_valid}, 64'd1);
    for (int n = 0; n < 3000 && (sb.size() != 0 || io.out_valid); n++) begin
      io.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    io.out_ready = 1'b1;
    wait_idle("burst");
    check("burst_completions", 64'(compl - k0), 64'(DEPTH + 1));

`ifdef MUL_FLUSH_EN
    push_op(5'b10000, 32'd3, 32'd4, 5'd21);
    push_op(5'b10001, 32'd5, 32'd6, 5'd22);
    push_op(5'b10011, 32'd7, 32'd8, 5'd23);
    while (cyc < last_start_cyc + 10) begin
      @(posedge clk); #1;
    end
    k0 = compl; v0 = vcyc; s0 = starts;
    io.flush = 1'b1;
    @(posedge clk); #1;
    io.flush = 1'b0;
    check("flush_q_count", {61'd0, io.q_count}, 64'd0);
    check("flush_out_valid", {63'd0, io.out_valid}, 64'd0);
    repeat (45) @(posedge clk);
    #1;
    check("flush_no_valid", 64'(vcyc - v0), 64'd0);
    check("flush_no_start", 64'(starts - s0), 64'd0);
    push_op(5'b10000, 32'd9, 32'd9, 5'd24);
    wait_idle("post_flush");
    check("post_flush_tag", {59'd0, last_tag}, 64'd24);
    check("post_flush_data", {32'd0, last_data}, 64'd81);
    check("post_flush_compl", 64'(compl - k0), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
